l2_bank_rr_arbiter: RTL
=======================

# l2_bank_rr_arbiter

Round-robin arbiter placed directly upstream of each L2 SRAM bank port (interleaved or private). It merges `NB_MASTERS` TCDM-36 request streams into one bank port. It tracks outstanding transactions in a small ID FIFO and routes each bank response, including its 4 DIFT tag bits, back to the master that issued the request. One instance is used per bank port.

## Interface
Parameters:
- `NB_MASTERS`, 3, number of upstream TCDM masters (≥2).
- `ID_FIFO_DEPTH`, 2, maximum number of outstanding granted requests awaiting `r_valid` (power of 2, ≥1).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `mst_slave[NB_MASTERS]`  XBAR_TCDM_BUS_36.Slave  —  upstream ports: `req`, `add[31:0]`, `wen` (1 = read), `wdata[35:0]`, `be[3:0]` in; `gnt`, `r_valid`, `r_rdata[35:0]`, `r_opc` out.
- `bank_master`  XBAR_TCDM_BUS_36.Master  —  downstream bank port with the same signals, directions mirrored.
- `err_o`  out  1  sticky flag: a bank `r_valid` arrived while the ID FIFO was empty.

## Operation
- **Arbitration (combinational).**
  - Candidates are all masters with `req`=1.
  - The winner is the first candidate found scanning from `rr_ptr` upward, modulo `NB_MASTERS`.
- **Forwarding.**
  - `bank_master.req` = any candidate present AND `can_push`.
  - `add`, `wen`, `wdata`, `be` are muxed from the winner unchanged. No address offset is removed here.
- **Grant.**
  - `mst_slave[w].gnt` = `bank_master.req` & `bank_master.gnt` for the winner `w`; 0 for every other master.
  - Handshake = `bank_master.req` & `bank_master.gnt`.
- **Round-robin pointer.** On a handshake, `rr_ptr` ← `(w+1) mod NB_MASTERS`; otherwise it holds.
- **ID FIFO.**
  - A handshake pushes `w`, which is `$clog2(NB_MASTERS)` bits wide.
  - `bank_master.r_valid` pops the head.
  - `can_push` = not full, OR full with a pop in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
- **Response routing.** While `bank_master.r_valid`=1 and the FIFO is not empty:
  - `mst_slave[head].r_valid`=1.
  - `r_rdata` and `r_opc` are copied from the bank.
  - All other masters see `r_valid`=0.
- **Error case.** `r_valid` with the FIFO empty:
  - The response is dropped and `err_o` is set.
  - `err_o` clears only on reset.
- `r_rdata` of non-selected masters is driven with the bank data, which is don't-care; `r_valid` is the only qualifier.

## Timing
- Reset values: `rr_ptr`=0, FIFO empty, `err_o`=0.
  - All `gnt` and `r_valid` outputs are 0 while `rst_i` is high.
  - `bank_master.req`=0 unless a master requests.
- Request path is combinational, zero added latency: master `req` → bank `req` → bank `gnt` → master `gnt` in the same cycle.
- Response latency equals the bank latency. With a 1-cycle bank, a master sees `r_valid` in cycle t+1 after the handshake in cycle t.
- Throughput: one handshake per cycle, provided `ID_FIFO_DEPTH` ≥ the bank latency.
- Full FIFO with no pop in the cycle: `bank_master.req`=0 and all `gnt`=0. Masters hold `req` per the TCDM rules.
- A master that drops `req` before its grant loses its slot; the pointer does not move.
- Reset asserted mid-operation:
  - In-flight IDs are discarded.
  - Responses arriving after release with the FIFO empty set `err_o`. The system must quiesce before reset.

## Configuration
- Macro: `L2_ARB_DIFT_TAG_EN`.
- Defined: `wdata[35:32]` is forwarded to the bank and `r_rdata[35:32]` is returned to the master unchanged.
- Undefined:
  - `bank_master.wdata[35:32]` is forced to 4'b0.
  - `mst_slave[*].r_rdata[35:32]` is forced to 4'b0.
  - Bits [31:0] are unaffected.

## Structure
- Package `l2_arb_pkg`:
  - `typedef logic [35:0] tcdm_data_t`.
  - `localparam int unsigned DIFT_TAG_W = 4`.
  - Function `mst_id_w(n)` returning `(n>1) ? $clog2(n) : 1`.
- Sub-module `l2_arb_id_fifo`, parameterised by width and depth:
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Async active-high reset; registered pointers and count.
- The top level holds the RR pointer, the priority scan, the muxes and `err_o`.

## Test plan
- **Single master.** M1 reads 0x1C00_0010 with a 1-cycle bank → `gnt` in cycle 0, M1 `r_valid` in cycle 1 with the bank data. M0 and M2 `r_valid` stay 0.
- **Full contention.** M0, M1 and M2 hold `req` for 6 cycles → grant order 0,1,2,0,1,2. Each response is returned to its issuer one cycle later.
- **FIFO full.** `ID_FIFO_DEPTH`=2, bank `r_valid` withheld for 3 cycles → 2 grants, then `gnt`=0 until the first `r_valid`. A grant is issued in that same cycle.
- **Spurious response.** Bank pulses `r_valid` with no outstanding request → no master `r_valid`, `err_o`=1 until reset.
- **DIFT tags.** Write `wdata`=36'hA_DEADBEEF, then read it back → with `L2_ARB_DIFT_TAG_EN`, `r_rdata`=36'hA_DEADBEEF. Without the macro, the bank sees tag 0 and the read returns 36'h0_DEADBEEF.
- **Reset mid-stream.** Assert `rst_i` with 2 IDs outstanding → `rr_ptr`=0, FIFO empty, all `gnt`/`r_valid` 0 on the next cycle.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg
//   Shared types and helpers for the L2 bank round-robin arbiter.
//   tcdm_data_t : 36-bit TCDM data word (32 data bits + 4 DIFT tag bits).
//   DIFT_TAG_W  : width of the DIFT tag carried in data bits [35:32].
//   mst_id_w(n) : width of a master index for n masters (at least 1 bit).
package l2_arb_pkg;

  typedef logic [35:0] tcdm_data_t;

  localparam int unsigned DIFT_TAG_W = 4;

  function automatic int unsigned mst_id_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/xbar_tcdm_bus_36.sv
// XBAR_TCDM_BUS_36
//   TCDM request/response bus with 36-bit data (32 data + 4 DIFT tag bits).
//   Request : req, add[31:0], wen (1 = read), wdata[35:0], be[3:0]
//   Response: gnt, r_valid, r_rdata[35:0], r_opc
//   Master drives the request and receives the response; Slave is the mirror.
interface XBAR_TCDM_BUS_36;
  import l2_arb_pkg::*;

  logic        req;
  logic [31:0] add;
  logic        wen;
  tcdm_data_t  wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  tcdm_data_t  r_rdata;
  logic        r_opc;

  modport Master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport Slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );

endinterface

// File: rtl/l2_arb_id_fifo.sv
// l2_arb_id_fifo
//   Small FIFO holding the master index of every granted, not yet answered
//   request. Storage is not reset; only pointers and count are.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     push, din    : enqueue din (ignored when full without a pop)
//     pop          : dequeue the head (ignored when empty)
//     dout         : current head
//     full, empty  : occupancy flags
module l2_arb_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter
//   Round-robin arbiter in front of one L2 SRAM bank port. Merges NB_MASTERS
//   TCDM-36 request streams into the bank port, remembers the issuer of each
//   granted request in an ID FIFO and routes bank responses back to it.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     mst_slave[]  : upstream TCDM slave ports, one per master
//     bank_master  : downstream bank port
//     err_o        : sticky, set when a bank response arrives with no
//                    outstanding request; cleared only by reset
//   Configuration macro L2_ARB_DIFT_TAG_EN: when defined the 4 DIFT tag bits
//   [35:32] pass through in both directions; otherwise they are forced to 0
//   towards the bank and towards the masters.
module l2_bank_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS    = 3,
  parameter int unsigned ID_FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  XBAR_TCDM_BUS_36.Slave  mst_slave [NB_MASTERS],
  XBAR_TCDM_BUS_36.Master bank_master,
  output logic            err_o
);

  localparam int unsigned ID_W = mst_id_w(NB_MASTERS);
  localparam int unsigned PAYLOAD_W = 32;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NB_MASTERS - 1);

  logic [NB_MASTERS-1:0] req_vec;
  logic [31:0]           add_vec   [NB_MASTERS];
  logic                  wen_vec   [NB_MASTERS];
  tcdm_data_t            wdata_vec [NB_MASTERS];
  logic [3:0]            be_vec    [NB_MASTERS];

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            bank_req;
  logic            hs;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            pop;
  logic            can_push;
  logic            rsp_vld;
  tcdm_data_t      rsp_data;

  for (genvar i = 0; i < NB_MASTERS; i++) begin : g_mst
    assign req_vec[i]   = mst_slave[i].req;
    assign add_vec[i]   = mst_slave[i].add;
    assign wen_vec[i]   = mst_slave[i].wen;
    assign wdata_vec[i] = mst_slave[i].wdata;
    assign be_vec[i]    = mst_slave[i].be;

    assign mst_slave[i].gnt     = hs & (winner == ID_W'(i));
    assign mst_slave[i].r_valid = rsp_vld & (fifo_head == ID_W'(i));
    assign mst_slave[i].r_rdata = rsp_data;
    assign mst_slave[i].r_opc   = bank_master.r_opc;
  end

  // First requester at or after rr_ptr, wrapping modulo NB_MASTERS.
  always_comb begin
    logic [ID_W:0] cand;
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NB_MASTERS)) begin
        cand = cand - (ID_W + 1)'(NB_MASTERS);
      end
      if (!any_req && req_vec[cand[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[ID_W-1:0];
      end
    end
  end

  assign pop      = bank_master.r_valid & ~fifo_empty;
  assign can_push = ~fifo_full | pop;
  assign bank_req = any_req & can_push & ~rst_i;
  assign hs       = bank_req & bank_master.gnt;
  assign rsp_vld  = pop & ~rst_i;

  assign bank_master.req = bank_req;
  assign bank_master.add = add_vec[winner];
  assign bank_master.wen = wen_vec[winner];
  assign bank_master.be  = be_vec[winner];

`ifdef L2_ARB_DIFT_TAG_EN
  assign bank_master.wdata = wdata_vec[winner];
  assign rsp_data          = bank_master.r_rdata;
`else
  assign bank_master.wdata = {DIFT_TAG_W'(0), wdata_vec[winner][PAYLOAD_W-1:0]};
  assign rsp_data          = {DIFT_TAG_W'(0), bank_master.r_rdata[PAYLOAD_W-1:0]};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
      end
      if (bank_master.r_valid && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  l2_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs),
    .pop   (bank_master.r_valid),
    .din   (winner),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
